// File: rtl/md_pkg.sv
// Shared definitions for the multicycle signed MULT/DIV engine.
//   md_state_t : engine control states
//   OP_MULT/OP_DIV : encoding of the op_i select
//   MD_WIDTH : default operand/result width
package md_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIN  = 2'd3
  } md_state_t;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int MD_WIDTH = 32;

endpackage : md_pkg

// File: rtl/mult_div_unit_div_step.sv
// div_step: one combinational restoring-division step on unsigned magnitudes.
// Ports:
//   rem_i     : partial remainder (always < divisor_i)
//   msb_i     : next dividend bit shifted into the remainder
//   divisor_i : divisor magnitude (non-zero)
//   rem_o     : next partial remainder
//   q_bit_o   : quotient bit produced by this step
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

  assign shifted = {rem_i, msb_i};
  assign fits    = (shifted >= {1'b0, divisor_i});
  // When the divisor fits, the true difference is below the divisor and thus
  // representable in WIDTH bits, so a modular WIDTH-bit subtract is exact.
  assign diff    = shifted[WIDTH-1:0] - divisor_i;

  assign rem_o   = fits ? diff : shifted[WIDTH-1:0];
  assign q_bit_o = fits;

endmodule : div_step

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed MULT (radix-2 Booth) / DIV (restoring on
// magnitudes), one step per clock, WIDTH steps per operation.
// Ports:
//   clk_i, rst_i      : clock (rising edge), asynchronous active-high reset
//   start_i, op_i     : request and op select (0 MULT, 1 DIV), taken in IDLE
//   a_i, b_i          : multiplicand/dividend, multiplier/divisor
//   busy_o            : high in every state except IDLE
//   done_o            : one-cycle pulse, hi_o/lo_o valid
//   div_zero_o        : one-cycle pulse with done_o for DIV by zero
//   hi_o, lo_o        : product high/low, or remainder/quotient
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             div_zero_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_t        state_q;
  logic [CNT_W-1:0] counter_q;
  // acc_q: Booth accumulator (WIDTH+1 bits) or partial remainder for DIV.
  // q_q  : multiplier bits being consumed, or dividend shifting into quotient.
  // m_q  : multiplicand, or divisor magnitude.
  logic [WIDTH:0]   acc_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] m_q;
  logic             qm1_q;
  logic             quo_neg_q;
  logic             rem_neg_q;
  logic             dz_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             last_step;
  assign last_step = (counter_q == CNT_W'(WIDTH - 1));

  // ---------------- Booth step ----------------
  logic [WIDTH:0]   m_ext;
  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   acc_mul_d;
  logic [WIDTH-1:0] q_mul_d;

  assign m_ext = {m_q[WIDTH-1], m_q};

  always_comb begin
    booth_sum = acc_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   booth_sum = acc_q + m_ext;
      2'b10:   booth_sum = acc_q - m_ext;
      default: booth_sum = acc_q;
    endcase
  end

  // Arithmetic right shift of the {acc, q, q-1} triple.
  assign acc_mul_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
  assign q_mul_d   = {booth_sum[0], q_q[WIDTH-1:1]};

  // ---------------- Restoring division step ----------------
  logic [WIDTH-1:0] rem_div_d;
  logic             q_bit;
  logic [WIDTH-1:0] quo_div_d;
  logic [WIDTH-1:0] lo_div_fix;
  logic [WIDTH-1:0] hi_div_fix;

  div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_i     (acc_q[WIDTH-1:0]),
    .msb_i     (q_q[WIDTH-1]),
    .divisor_i (m_q),
    .rem_o     (rem_div_d),
    .q_bit_o   (q_bit)
  );

  assign quo_div_d  = {q_q[WIDTH-2:0], q_bit};
  // Sign correction: quotient negative when operand signs differ, remainder
  // follows the dividend sign.
  assign lo_div_fix = quo_neg_q ? (~quo_div_d + 1'b1) : quo_div_d;
  assign hi_div_fix = rem_neg_q ? (~rem_div_d + 1'b1) : rem_div_d;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // the correct unsigned magnitude.
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  assign abs_a = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
  assign abs_b = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;

  // ---------------- Control FSM and datapath registers ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      counter_q <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            counter_q <= '0;
            acc_q     <= '0;
            qm1_q     <= 1'b0;
            dz_q      <= 1'b0;
            if (op_i == OP_MULT) begin
              q_q     <= b_i;
              m_q     <= a_i;
              state_q <= MUL;
            end else if (b_i == '0) begin
              dz_q    <= 1'b1;
              state_q <= FIN;
            end else begin
              q_q       <= abs_a;
              m_q       <= abs_b;
              rem_neg_q <= a_i[WIDTH-1];
              quo_neg_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
              state_q   <= DIV;
            end
          end
        end
        MUL: begin
          acc_q     <= acc_mul_d;
          q_q       <= q_mul_d;
          qm1_q     <= q_q[0];
          counter_q <= counter_q + CNT_W'(1);
          if (last_step) begin
            hi_q    <= acc_mul_d[WIDTH-1:0];
            lo_q    <= q_mul_d;
            state_q <= FIN;
          end
        end
        DIV: begin
          acc_q     <= {1'b0, rem_div_d};
          q_q       <= quo_div_d;
          counter_q <= counter_q + CNT_W'(1);
          if (last_step) begin
            hi_q    <= hi_div_fix;
            lo_q    <= lo_div_fix;
            state_q <= FIN;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == FIN);
  assign div_zero_o = (state_q == FIN) && dz_q;
  assign hi_o       = hi_q;
  assign lo_o       = lo_q;

endmodule : mult_div_unit

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        dz;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .op_i       (op),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .done_o     (done),
    .div_zero_o (dz),
    .hi_o       (hi),
    .lo_o       (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one op and wait for Done. lat = rising edges after the accept edge
  // at which Done was first seen high (-1 on timeout).
  task automatic do_op(input logic op_v, input logic [31:0] a_v, input logic [31:0] b_v,
                       output int lat, output logic busy_ok, output logic pulse_ok,
                       output logic dz_seen);
    @(negedge clk);
    start = 1'b1; op = op_v; a = a_v; b = b_v;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; busy_ok = 1'b1; pulse_ok = 1'b0; dz_seen = 1'b0;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        dz_seen = dz;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
    if (lat >= 0) begin
      @(negedge clk);
      pulse_ok = !done;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL reset_dz got %0b exp 0", dz); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", lo); end
    $display("reset: busy=%0b done=%0b hi=%h lo=%h", busy, done, hi, lo);
  endtask

  task automatic test_mult();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] eh [3];
    logic [31:0] el [3];
    int lat; logic bok, pok, dzs;
    va[0] = 32'd7;        vb[0] = 32'hFFFFFFFD; eh[0] = 32'hFFFFFFFF; el[0] = 32'hFFFFFFEB;
    va[1] = 32'h80000000; vb[1] = 32'h80000000; eh[1] = 32'h40000000; el[1] = 32'h00000000;
    va[2] = 32'hFFFFFFFF; vb[2] = 32'hFFFFFFFF; eh[2] = 32'h00000000; el[2] = 32'h00000001;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, va[i], vb[i], lat, bok, pok, dzs);
      $display("mult %h*%h: hi=%h lo=%h lat=%0d", va[i], vb[i], hi, lo, lat);
      checks++; if (hi !== eh[i]) begin errors++; $display("FAIL mult%0d_hi got %h exp %h", i, hi, eh[i]); end
      checks++; if (lo !== el[i]) begin errors++; $display("FAIL mult%0d_lo got %h exp %h", i, lo, el[i]); end
      checks++; if (dzs !== 1'b0) begin errors++; $display("FAIL mult%0d_dz got %0b exp 0", i, dzs); end
      if (i == 0) begin
        checks++; if (lat != 32) begin errors++; $display("FAIL mult_latency got %0d exp 32", lat); end
        checks++; if (bok !== 1'b1) begin errors++; $display("FAIL mult_busy got %0b exp 1", bok); end
        checks++; if (pok !== 1'b1) begin errors++; $display("FAIL mult_done_pulse got %0b exp 1", pok); end
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] va [3];
    logic [31:0] vb [3];
    logic [31:0] eh [3];
    logic [31:0] el [3];
    int lat; logic bok, pok, dzs;
    va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;        eh[0] = 32'hFFFFFFFF; el[0] = 32'hFFFFFFFD;
    va[1] = 32'd7;        vb[1] = 32'hFFFFFFFE; eh[1] = 32'h00000001; el[1] = 32'hFFFFFFFD;
    va[2] = 32'h80000000; vb[2] = 32'hFFFFFFFF; eh[2] = 32'h00000000; el[2] = 32'h80000000;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, va[i], vb[i], lat, bok, pok, dzs);
      $display("div %h/%h: hi=%h lo=%h lat=%0d", va[i], vb[i], hi, lo, lat);
      checks++; if (hi !== eh[i]) begin errors++; $display("FAIL div%0d_hi got %h exp %h", i, hi, eh[i]); end
      checks++; if (lo !== el[i]) begin errors++; $display("FAIL div%0d_lo got %h exp %h", i, lo, el[i]); end
      checks++; if (dzs !== 1'b0) begin errors++; $display("FAIL div%0d_dz got %0b exp 0", i, dzs); end
      checks++; if (lat != 32) begin errors++; $display("FAIL div%0d_latency got %0d exp 32", i, lat); end
    end
  endtask

  task automatic test_div_zero();
    int lat; logic bok, pok, dzs;
    do_op(1'b0, 32'd3, 32'd5, lat, bok, pok, dzs);
    $display("mult 3*5: hi=%h lo=%h", hi, lo);
    checks++; if (lo !== 32'd15) begin errors++; $display("FAIL preload_lo got %h exp 0000000f", lo); end
    do_op(1'b1, 32'd5, 32'd0, lat, bok, pok, dzs);
    $display("div 5/0: hi=%h lo=%h lat=%0d dz=%0b", hi, lo, lat, dzs);
    checks++; if (lat != 0) begin errors++; $display("FAIL divzero_latency got %0d exp 0", lat); end
    checks++; if (dzs !== 1'b1) begin errors++; $display("FAIL divzero_flag got %0b exp 1", dzs); end
    checks++; if (pok !== 1'b1) begin errors++; $display("FAIL divzero_pulse got %0b exp 1", pok); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL divzero_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'd15) begin errors++; $display("FAIL divzero_lo got %h exp 0000000f", lo); end
  endtask

  task automatic test_busy_ignore();
    int lat; logic bok, pok, dzs;
    logic [31:0] hi_s, lo_s;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd6; b = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1; hi_s = '0; lo_s = '0;
    for (int n = 0; n < 40 && lat < 0; n++) begin
      @(negedge clk);
      // From here on keep a different request asserted through Busy and FIN.
      if (n == 2) begin start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd3; end
      if (done) begin lat = n; hi_s = hi; lo_s = lo; end
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    $display("busy_ignore 6*7: hi=%h lo=%h lat=%0d busy_after=%0b", hi_s, lo_s, lat, busy);
    checks++; if (lat != 32) begin errors++; $display("FAIL ignore_latency got %0d exp 32", lat); end
    checks++; if (lo_s !== 32'd42) begin errors++; $display("FAIL ignore_lo got %h exp 0000002a", lo_s); end
    checks++; if (hi_s !== 32'd0) begin errors++; $display("FAIL ignore_hi got %h exp 0", hi_s); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_fin_start got busy %0b exp 0", busy); end
    checks++; if (lo !== 32'd42) begin errors++; $display("FAIL ignore_hold_lo got %h exp 0000002a", lo); end
    do_op(1'b0, 32'd2, 32'd2, lat, bok, pok, dzs);
    $display("mult 2*2 after ignore: hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++; if (lo !== 32'd4) begin errors++; $display("FAIL next_start_lo got %h exp 4", lo); end
    checks++; if (lat != 32) begin errors++; $display("FAIL next_start_latency got %0d exp 32", lat); end
  endtask

  task automatic test_reset_mid();
    int lat; logic bok, pok, dzs;
    int done_cnt;
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'h00012345; b = 32'h00000777;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    $display("reset_mid: busy=%0b hi=%h lo=%h", busy, hi, lo);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %0b exp 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midreset_hi got %h exp 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midreset_lo got %h exp 0", lo); end
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL midreset_no_done got %0d exp 0", done_cnt); end
    do_op(1'b0, 32'd2, 32'd3, lat, bok, pok, dzs);
    $display("mult 2*3 after reset: hi=%h lo=%h lat=%0d", hi, lo, lat);
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL postreset_lo got %h exp 6", lo); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL postreset_hi got %h exp 0", hi); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_busy_ignore();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mult_div_unit
